// File: rtl/vpg_mode_pkg.sv
// ---------------------------------------------------------------------------
// vpg_mode_pkg : state encoding, mode indices and timing table for vpg_mode_ctrl
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package vpg_mode_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_VB  = 3'd1,
    ST_HOLD     = 3'd2,
    ST_PLL_REQ  = 3'd3,
    ST_PLL_WAIT = 3'd4,
    ST_SETTLE   = 3'd5
  } state_t;

  localparam int unsigned C_MODE_W     = 3;
  localparam int unsigned C_MODE_COUNT = 3;
  localparam int unsigned C_VS_CNT_W   = 22;

  localparam logic [C_MODE_W-1:0] C_MODE_640  = 3'd0;
  localparam logic [C_MODE_W-1:0] C_MODE_720  = 3'd1;
  localparam logic [C_MODE_W-1:0] C_MODE_1080 = 3'd2;

  typedef struct packed {
    logic [11:0] h_total;
    logic [11:0] h_sync;
    logic [11:0] h_start;
    logic [11:0] h_end;
    logic [11:0] v_total;
    logic [11:0] v_sync;
    logic [11:0] v_start;
    logic [11:0] v_end;
    logic [11:0] v_active_14;
    logic [11:0] v_active_24;
    logic [11:0] v_active_34;
  } timing_t;

  localparam timing_t C_TIMING_640 = '{
    h_total: 12'd799,  h_sync: 12'd95, h_start: 12'd141, h_end: 12'd781,
    v_total: 12'd524,  v_sync: 12'd1,  v_start: 12'd34,  v_end: 12'd514,
    v_active_14: 12'd154, v_active_24: 12'd274, v_active_34: 12'd394};

  localparam timing_t C_TIMING_720 = '{
    h_total: 12'd1649, h_sync: 12'd39, h_start: 12'd259, h_end: 12'd1539,
    v_total: 12'd749,  v_sync: 12'd4,  v_start: 12'd24,  v_end: 12'd744,
    v_active_14: 12'd204, v_active_24: 12'd384, v_active_34: 12'd564};

  localparam timing_t C_TIMING_1080 = '{
    h_total: 12'd2199, h_sync: 12'd43, h_start: 12'd189, h_end: 12'd2109,
    v_total: 12'd1124, v_sync: 12'd4,  v_start: 12'd40,  v_end: 12'd1120,
    v_active_14: 12'd310, v_active_24: 12'd580, v_active_34: 12'd850};

endpackage

`default_nettype wire

// File: rtl/vpg_mode_rom.sv
// ---------------------------------------------------------------------------
// vpg_mode_rom : combinational mode index -> timing parameters + valid flag
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vpg_mode_rom
  import vpg_mode_pkg::*;
(
  input  logic [C_MODE_W-1:0] mode,
  output timing_t             timing,
  output logic                valid
);

  always_comb begin
    timing = C_TIMING_640;
    valid  = 1'b0;
    case (mode)
      C_MODE_640:  begin timing = C_TIMING_640;  valid = 1'b1; end
      C_MODE_720:  begin timing = C_TIMING_720;  valid = 1'b1; end
      C_MODE_1080: begin timing = C_TIMING_1080; valid = 1'b1; end
      default:     ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/vpg_mode_ctrl.sv
// ---------------------------------------------------------------------------
// vpg_mode_ctrl : video mode switch sequencer; VPG_MODE_PLL_EN adds the PLL handshake
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vpg_mode_ctrl
  import vpg_mode_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned VS_TIMEOUT    = 4194303
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [C_MODE_W-1:0] mode_req,
  input  logic                mode_req_valid,
  output logic                mode_req_ready,
  input  logic                vga_vs,
  output logic                gen_reset_n,
  output logic [11:0]         h_total,
  output logic [11:0]         h_sync,
  output logic [11:0]         h_start,
  output logic [11:0]         h_end,
  output logic [11:0]         v_total,
  output logic [11:0]         v_sync,
  output logic [11:0]         v_start,
  output logic [11:0]         v_end,
  output logic [11:0]         v_active_14,
  output logic [11:0]         v_active_24,
  output logic [11:0]         v_active_34,
  output logic                pll_req,
  output logic [C_MODE_W-1:0] pll_mode,
  input  logic                pll_ack,
  output logic [C_MODE_W-1:0] mode_cur,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int unsigned C_SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [C_SETTLE_W-1:0] C_SETTLE_LAST = C_SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [C_VS_CNT_W-1:0] C_VS_LAST     = C_VS_CNT_W'(VS_TIMEOUT - 1);

  state_t                r_state, w_state_nxt;
  logic                  r_vs_d1, r_vs_d2, w_vs_fall;
  logic [C_VS_CNT_W-1:0] r_vs_cnt;
  logic [C_SETTLE_W-1:0] r_settle_cnt;
  logic [C_MODE_W-1:0]   r_mode_new, r_mode_cur, w_rom_idx;
  timing_t               r_timing, w_rom_timing;
  logic                  w_rom_valid;
  logic                  r_gen_rst_n, r_done, r_err;
  logic                  w_gen_rst_n_nxt, w_done_nxt, w_err_nxt, w_accept, w_load;
  logic                  r_pll_req, w_pll_req_nxt;

  // Requests are validated in IDLE; elsewhere the ROM serves the latched target.
  assign w_rom_idx = (r_state == ST_IDLE) ? mode_req : r_mode_new;

  vpg_mode_rom u_rom (
    .mode   (w_rom_idx),
    .timing (w_rom_timing),
    .valid  (w_rom_valid)
  );

  assign w_vs_fall = r_vs_d2 & ~r_vs_d1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_SETTLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_gen_rst_n_nxt = r_gen_rst_n;
    w_pll_req_nxt   = r_pll_req;
    w_done_nxt      = 1'b0;
    w_err_nxt       = 1'b0;
    w_accept        = 1'b0;
    w_load          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (mode_req_valid) begin
          if (!w_rom_valid) begin
            w_err_nxt = 1'b1;
          end else if (mode_req == r_mode_cur) begin
            w_done_nxt = 1'b1;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = ST_WAIT_VB;
          end
        end
      end
      ST_WAIT_VB: begin
        if (w_vs_fall || (r_vs_cnt == C_VS_LAST)) begin
          w_gen_rst_n_nxt = 1'b0;
          w_state_nxt     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        w_load = 1'b1;
`ifdef VPG_MODE_PLL_EN
        w_pll_req_nxt = 1'b1;
        w_state_nxt   = ST_PLL_REQ;
`else
        w_state_nxt   = ST_SETTLE;
`endif
      end
`ifdef VPG_MODE_PLL_EN
      ST_PLL_REQ: begin
        if (pll_ack) begin
          w_pll_req_nxt = 1'b0;
          w_state_nxt   = ST_PLL_WAIT;
        end
      end
      ST_PLL_WAIT: begin
        if (!pll_ack) w_state_nxt = ST_SETTLE;
      end
`endif
      ST_SETTLE: begin
        if (r_settle_cnt == C_SETTLE_LAST) begin
          w_gen_rst_n_nxt = 1'b1;
          w_done_nxt      = 1'b1;
          w_state_nxt     = ST_IDLE;
        end
      end
      default: begin
        w_gen_rst_n_nxt = 1'b0;
        w_pll_req_nxt   = 1'b0;
        w_state_nxt     = ST_SETTLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vs_d1      <= 1'b1;
      r_vs_d2      <= 1'b1;
      r_vs_cnt     <= '0;
      r_settle_cnt <= '0;
      r_mode_new   <= C_MODE_640;
      r_mode_cur   <= C_MODE_640;
      r_timing     <= C_TIMING_640;
      r_gen_rst_n  <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_vs_d1     <= vga_vs;
      r_vs_d2     <= r_vs_d1;
      r_gen_rst_n <= w_gen_rst_n_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      // Saturating: the timeout counter must never wrap back to zero.
      if (r_state != ST_WAIT_VB)  r_vs_cnt <= '0;
      else if (r_vs_cnt != '1)    r_vs_cnt <= r_vs_cnt + C_VS_CNT_W'(1);
      if (r_state != ST_SETTLE || r_settle_cnt == C_SETTLE_LAST) r_settle_cnt <= '0;
      else                                                       r_settle_cnt <= r_settle_cnt + C_SETTLE_W'(1);
      if (w_accept) r_mode_new <= mode_req;
      if (w_load) begin
        r_timing   <= w_rom_timing;
        r_mode_cur <= r_mode_new;
      end
    end
  end

`ifdef VPG_MODE_PLL_EN
  logic [C_MODE_W-1:0] r_pll_mode;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pll_req  <= 1'b0;
      r_pll_mode <= C_MODE_640;
    end else begin
      r_pll_req <= w_pll_req_nxt;
      if (w_load) r_pll_mode <= r_mode_new;
    end
  end

  assign pll_req  = r_pll_req;
  assign pll_mode = r_pll_mode;
`else
  logic w_pll_unused;

  assign r_pll_req    = 1'b0;
  assign w_pll_unused = pll_ack | w_pll_req_nxt;
  assign pll_req      = 1'b0;
  assign pll_mode     = r_mode_cur;
`endif

  assign mode_req_ready = (r_state == ST_IDLE);
  assign busy           = (r_state != ST_IDLE);
  assign gen_reset_n    = r_gen_rst_n;
  assign done           = r_done;
  assign err            = r_err;
  assign mode_cur       = r_mode_cur;
  assign h_total        = r_timing.h_total;
  assign h_sync         = r_timing.h_sync;
  assign h_start        = r_timing.h_start;
  assign h_end          = r_timing.h_end;
  assign v_total        = r_timing.v_total;
  assign v_sync         = r_timing.v_sync;
  assign v_start        = r_timing.v_start;
  assign v_end          = r_timing.v_end;
  assign v_active_14    = r_timing.v_active_14;
  assign v_active_24    = r_timing.v_active_24;
  assign v_active_34    = r_timing.v_active_34;

endmodule

`default_nettype wire

// File: tb/tb_vpg_mode_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vpg_mode_ctrl : directed self-checking bench for vpg_mode_ctrl (VPG_MODE_PLL_EN aware)
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_vpg_mode_ctrl;

  localparam int unsigned SETTLE = 16;
  localparam int unsigned VS_TO  = 1000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  mode_req = 3'd0;
  logic        mode_req_valid = 1'b0;
  logic        mode_req_ready;
  logic        vga_vs = 1'b1;
  logic        gen_reset_n;
  logic [11:0] h_total, h_sync, h_start, h_end;
  logic [11:0] v_total, v_sync, v_start, v_end;
  logic [11:0] v_active_14, v_active_24, v_active_34;
  logic        pll_req;
  logic [2:0]  pll_mode;
  logic        pll_ack = 1'b0;
  logic [2:0]  mode_cur;
  logic        busy, done, err;

  int n_cmp = 0;
  int n_bad = 0;

  vpg_mode_ctrl #(
    .SETTLE_CYCLES (SETTLE),
    .VS_TIMEOUT    (VS_TO)
  ) u_dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .mode_req       (mode_req),
    .mode_req_valid (mode_req_valid),
    .mode_req_ready (mode_req_ready),
    .vga_vs         (vga_vs),
    .gen_reset_n    (gen_reset_n),
    .h_total        (h_total),
    .h_sync         (h_sync),
    .h_start        (h_start),
    .h_end          (h_end),
    .v_total        (v_total),
    .v_sync         (v_sync),
    .v_start        (v_start),
    .v_end          (v_end),
    .v_active_14    (v_active_14),
    .v_active_24    (v_active_24),
    .v_active_34    (v_active_34),
    .pll_req        (pll_req),
    .pll_mode       (pll_mode),
    .pll_ack        (pll_ack),
    .mode_cur       (mode_cur),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  always #5 clk = ~clk;

  // Event monitors sampled on the inactive edge.
  int          done_seen = 0;
  int          pll_seen  = 0;
  int          par_viol  = 0;
  logic [11:0] h_prev = 12'd799;
  logic [11:0] v_prev = 12'd514;

  always @(negedge clk) begin
    if (done) done_seen++;
    if (pll_req) pll_seen++;
    if (gen_reset_n && (h_total != h_prev || v_end != v_prev)) par_viol++;
    h_prev = h_total;
    v_prev = v_end;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic boot();
    int p0;
    reset_n        = 1'b0;
    mode_req_valid = 1'b0;
    pll_ack        = 1'b0;
    vga_vs         = 1'b1;
    repeat (3) tick();
    chk("rst_gen_reset_n", gen_reset_n, 0);
    chk("rst_mode_cur", mode_cur, 0);
    chk("rst_busy", busy, 1);
    chk("rst_ready", mode_req_ready, 0);
    chk("rst_done_err", {done, err}, 0);
    chk("rst_pll", {pll_req, pll_mode}, 0);
    chk("rst_h_total", h_total, 799);
    p0 = pll_seen;
    reset_n = 1'b1;
    for (int k = 1; k <= int'(SETTLE); k++) begin
      tick();
      if (k == int'(SETTLE) - 1) chk("boot_still_held", gen_reset_n, 0);
    end
    chk("boot_gen_reset_n", gen_reset_n, 1);
    chk("boot_done", done, 1);
    chk("boot_h_total", h_total, 799);
    chk("boot_mode_cur", mode_cur, 0);
    chk("boot_ready", mode_req_ready, 1);
    chk("boot_busy", busy, 0);
    tick();
    chk("boot_no_pll", pll_seen - p0, 0);
  endtask

  initial begin
    int n;
    int d0;
    int v0;

    boot();

    // Invalid mode request.
    mode_req = 3'd5; mode_req_valid = 1'b1;
    tick();
    mode_req_valid = 1'b0;
    chk("inv_err", err, 1);
    chk("inv_ready", mode_req_ready, 1);
    chk("inv_mode_cur", mode_cur, 0);
    chk("inv_h_total", h_total, 799);
    chk("inv_gen", gen_reset_n, 1);
    chk("inv_busy_done", {busy, done}, 0);
    tick();
    chk("inv_err_clear", err, 0);

    // Same-mode request.
    mode_req = 3'd0; mode_req_valid = 1'b1;
    tick();
    mode_req_valid = 1'b0;
    chk("same_done", done, 1);
    chk("same_gen", gen_reset_n, 1);
    chk("same_busy_err", {busy, err}, 0);
    tick();
    chk("same_done_clear", done, 0);
    chk("same_gen_after", gen_reset_n, 1);

    // Switch to mode 1 on a vsync edge.
    d0 = done_seen;
    v0 = par_viol;
    mode_req = 3'd1; mode_req_valid = 1'b1;
    tick();
    mode_req_valid = 1'b0;
    chk("sw_busy", busy, 1);
    chk("sw_ready", mode_req_ready, 0);
    chk("sw_gen_wait", gen_reset_n, 1);
    repeat (99) tick();
    vga_vs = 1'b0;
    tick();
    chk("sw_edge_sync", gen_reset_n, 1);
    tick();
    chk("sw_hold_gen", gen_reset_n, 0);
    chk("sw_hold_old_h", h_total, 799);
    chk("sw_hold_old_mode", mode_cur, 0);
    tick();
    vga_vs = 1'b1;
    chk("sw_h_total", h_total, 1649);
    chk("sw_v_end", v_end, 744);
    chk("sw_v_active_34", v_active_34, 564);
    chk("sw_mode_cur", mode_cur, 1);
    chk("sw_gen_low", gen_reset_n, 0);
`ifdef VPG_MODE_PLL_EN
    chk("sw_pll_req", pll_req, 1);
    chk("sw_pll_mode", pll_mode, 1);
    repeat (4) tick();
    chk("sw_pll_req_held", pll_req, 1);
    pll_ack = 1'b1;
    tick();
    chk("sw_pll_req_drop", pll_req, 0);
    pll_ack = 1'b0;
    tick();
`else
    chk("sw_pll_req_tied", pll_req, 0);
    chk("sw_pll_mode_track", pll_mode, 1);
`endif
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    chk("sw_settle_len", n, SETTLE);
    chk("sw_gen_release", gen_reset_n, 1);
    chk("sw_busy_end", busy, 0);
    chk("sw_final_mode", mode_cur, 1);
    tick();
    chk("sw_done_once", done_seen - d0, 1);
    chk("sw_param_stable", par_viol - v0, 0);

    // Switch to mode 2 with vsync held high: timeout path.
    mode_req = 3'd2; mode_req_valid = 1'b1;
    tick();
    mode_req_valid = 1'b0;
    n = 0;
    while (gen_reset_n && n < 1100) begin
      tick();
      n++;
    end
    chk("to_hold_delay", n, VS_TO);
    tick();
    chk("to_h_total", h_total, 2199);
    chk("to_v_total", v_total, 1124);
`ifdef VPG_MODE_PLL_EN
    chk("to_pll_mode", pll_mode, 2);
    pll_ack = 1'b1;
    tick();
    chk("to_pll_drop", pll_req, 0);
    tick();
`else
    tick();
`endif

    // Asynchronous reset mid-switch.
    reset_n = 1'b0;
    #1;
    chk("abort_pll_req", pll_req, 0);
    chk("abort_gen", gen_reset_n, 0);
    chk("abort_mode_cur", mode_cur, 0);
    chk("abort_h_total", h_total, 799);
    chk("abort_busy_ready", {busy, mode_req_ready}, 2'b10);
    boot();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
